pic_interrupt_sequencer: RTL



---
 rtl/pic_interrupt_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pic_interrupt_sequencer.sv
// 8259-style interrupt sequencer: IRR latching, fixed-priority resolve, two-pulse INTA and EOI.
// Optional macro PIC_EDGE_TRIGGER_EN selects edge-triggered IRR capture (level mode when undefined).
module pic_interrupt_sequencer #(
  parameter int         VEC_HI_W   = 5,
  parameter logic [2:0] SPUR_LEVEL = 3'd7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          irq_in,
  input  logic [7:0]          imr,
  input  logic [VEC_HI_W-1:0] vector_base,
  input  logic                aeoi_mode,
  input  logic                inta_n,
  input  logic                eoi_cmd,
  input  logic                seoi_cmd,
  input  logic [2:0]          seoi_level,
  output logic                int_out,
  output logic [7:0]          vector_out,
  output logic                vector_valid,
  output logic [7:0]          irr,
  output logic [7:0]          isr
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_ACK1 = 3'd2,
    ST_GAP  = 3'd3,
    ST_ACK2 = 3'd4
  } state_t;

  // Index of the lowest set bit (highest priority); 0 when the vector is empty.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    casez (v)
      8'b???????1: lowest_idx = 3'd0;
      8'b??????10: lowest_idx = 3'd1;
      8'b?????100: lowest_idx = 3'd2;
      8'b????1000: lowest_idx = 3'd3;
      8'b???10000: lowest_idx = 3'd4;
      8'b??100000: lowest_idx = 3'd5;
      8'b?1000000: lowest_idx = 3'd6;
      8'b10000000: lowest_idx = 3'd7;
      default:     lowest_idx = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'(8'd1 << idx);
  endfunction

  state_t     state_r, state_s;
  logic       inta_q_r;
  logic [2:0] win_r, win_s;
  logic       spur_r, spur_s;
  logic       int_out_s, vector_valid_s;
  logic [7:0] vector_out_s, irr_s, isr_s;
  logic [7:0] isr_set_s, isr_aeoi_clr_s, irr_clr_s, isr_seoi_s, isr_eoi_s;
  logic [7:0] masked_s;
  logic [2:0] cand_s, isr_low_s;
  logic       eligible_s, inta_fall_s, inta_rise_s;

`ifdef PIC_EDGE_TRIGGER_EN
  logic [7:0] irq_q_r;

  // Previous irq_in sample for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q_r <= 8'h00;
    end else begin
      irq_q_r <= irq_in;
    end
  end
`endif

  assign inta_fall_s = inta_q_r & ~inta_n;
  assign inta_rise_s = ~inta_q_r & inta_n;
  assign masked_s    = irr & ~imr;
  assign cand_s      = lowest_idx(masked_s);
  assign isr_low_s   = lowest_idx(isr);
  assign eligible_s  = (|masked_s) && ((isr == 8'h00) || (cand_s < isr_low_s));

  // Acknowledge sequencer: next state, win latch and registered output values.
  always_comb begin
    state_s        = state_r;
    win_s          = win_r;
    spur_s         = spur_r;
    int_out_s      = int_out;
    vector_out_s   = vector_out;
    vector_valid_s = vector_valid;
    isr_set_s      = 8'h00;
    isr_aeoi_clr_s = 8'h00;
    irr_clr_s      = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (eligible_s) begin
          state_s   = ST_PEND;
          int_out_s = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_PEND: begin
        int_out_s = 1'b1;
        if (inta_fall_s) begin
          state_s = ST_ACK1;
          // A request that vanished or got masked before INTA becomes spurious.
          if (eligible_s) begin
            win_s     = cand_s;
            spur_s    = 1'b0;
            isr_set_s = onehot(cand_s);
            irr_clr_s = onehot(cand_s);
          end else begin
            win_s     = SPUR_LEVEL;
            spur_s    = 1'b1;
          end
        end else begin
          state_s = ST_PEND;
        end
      end
      ST_ACK1: begin
        if (inta_rise_s) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_ACK1;
        end
      end
      ST_GAP: begin
        if (inta_fall_s) begin
          state_s        = ST_ACK2;
          vector_out_s   = 8'({vector_base, win_r});
          vector_valid_s = 1'b1;
          int_out_s      = 1'b0;
        end else begin
          state_s        = ST_GAP;
        end
      end
      ST_ACK2: begin
        if (inta_rise_s) begin
          state_s        = ST_IDLE;
          vector_valid_s = 1'b0;
          if (aeoi_mode && !spur_r) begin
            isr_aeoi_clr_s = onehot(win_r);
          end else begin
            isr_aeoi_clr_s = 8'h00;
          end
        end else begin
          state_s        = ST_ACK2;
        end
      end
      default: begin
        state_s        = ST_IDLE;
        int_out_s      = 1'b0;
        vector_valid_s = 1'b0;
      end
    endcase
  end

  // ISR update: specific EOI, then non-specific on the remainder, then auto-EOI; a set always wins.
  always_comb begin
    if (seoi_cmd) begin
      isr_seoi_s = isr & ~onehot(seoi_level);
    end else begin
      isr_seoi_s = isr;
    end
    if (eoi_cmd && (isr_seoi_s != 8'h00)) begin
      isr_eoi_s = isr_seoi_s & ~onehot(lowest_idx(isr_seoi_s));
    end else begin
      isr_eoi_s = isr_seoi_s;
    end
    isr_s = (isr_eoi_s & ~isr_aeoi_clr_s) | isr_set_s;
  end

  // IRR next value; the acknowledged level is dropped on the first INTA pulse.
  always_comb begin
`ifdef PIC_EDGE_TRIGGER_EN
    irr_s = (irr | (irq_in & ~irq_q_r)) & irq_in & ~irr_clr_s;
`else
    irr_s = irq_in & ~irr_clr_s;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      inta_q_r     <= 1'b1;
      win_r        <= 3'd0;
      spur_r       <= 1'b0;
      int_out      <= 1'b0;
      vector_out   <= 8'h00;
      vector_valid <= 1'b0;
      irr          <= 8'h00;
      isr          <= 8'h00;
    end else begin
      state_r      <= state_s;
      inta_q_r     <= inta_n;
      win_r        <= win_s;
      spur_r       <= spur_s;
      int_out      <= int_out_s;
      vector_out   <= vector_out_s;
      vector_valid <= vector_valid_s;
      irr          <= irr_s;
      isr          <= isr_s;
    end
  end

endmodule
